// File: rtl/nn_ctrl_pkg.sv
// rtl/nn_ctrl_pkg.sv - shared types and constants for the layer control blocks
//
// Purpose: sequencer state encoding, the ROM-pipe token carried alongside
// each issued row, and the deepest supported ROM read latency.
package nn_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } token_t;

  localparam int MAX_RD_LAT = 4;

endpackage

// File: rtl/valid_delay_line.sv
// rtl/valid_delay_line.sv - fixed-depth shift register for ROM-pipe tokens
//
// Purpose: delays each issue token by DEPTH cycles so it lines up with the
// ROM data it describes.
// Ports:
//   clk       in   system clock
//   rst_n     in   synchronous active-low clear of every stage
//   token_in  in   token entering this cycle (valid=0 for a bubble)
//   token_out out  token entered DEPTH cycles earlier
module valid_delay_line
  import nn_ctrl_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  token_t token_in,
  output token_t token_out
);

  token_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= token_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign token_out = stage[DEPTH-1];

endmodule

// File: rtl/weight_fetch_sequencer.sv
// rtl/weight_fetch_sequencer.sv - row sequencer for a fully connected layer's weight ROMs
//
// Purpose: steps a shared row index 0..len-1, broadcasts it to every node
// ROM and the activation buffer, and emits MAC strobes aligned to ROM data.
// Ports:
//   clk, rst_n       clock and synchronous active-low reset
//   start            launch request, honoured only in IDLE
//   depth_cfg        rows for this layer, latched on an accepted start
//   hold             freezes address issue while in ISSUE
//   busy             ISSUE through the last mac_en cycle
//   done             one-cycle completion pulse
//   rom_addr         row index replicated into every node slice
//   act_addr         row index for the activation buffer
//   mac_en/first/last  ROM data valid, first beat, final beat
module weight_fetch_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int NUM_NODES  = 32,
  parameter int DEPTH      = 784,
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LAT     = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [ADDR_WIDTH-1:0]           depth_cfg,
  input  logic                            hold,
  output logic                            busy,
  output logic                            done,
  output logic [ADDR_WIDTH*NUM_NODES-1:0] rom_addr,
  output logic [ADDR_WIDTH-1:0]           act_addr,
  output logic                            mac_en,
  output logic                            mac_first,
  output logic                            mac_last
);

  // Out-of-range latencies saturate rather than building a broken pipe.
  localparam int PIPE_DEPTH = (RD_LAT > MAX_RD_LAT) ? MAX_RD_LAT :
                              (RD_LAT < 1) ? 1 : RD_LAT;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_MAX = ADDR_WIDTH'(DEPTH);

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] idx, len;
  logic [ADDR_WIDTH-1:0] len_clamped;
  logic                  issue, issue_last;
  token_t                tok_in, tok_out;

  assign len_clamped = (depth_cfg > DEPTH_MAX) ? DEPTH_MAX : depth_cfg;
  assign issue_last  = (idx == len - 1'b1);

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    tok_in   = '0;
    case (state)
      IDLE: begin
        // An empty layer still passes through DRAIN so its done pulse lands
        // one cycle later, matching the pipelined completion timing.
        if (start) state_nx = (len_clamped == '0) ? DRAIN : ISSUE;
      end
      ISSUE: begin
        if (!hold) begin
          issue        = 1'b1;
          tok_in.valid = 1'b1;
          tok_in.first = (idx == '0);
          tok_in.last  = issue_last;
          if (issue_last) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if ((tok_out.valid && tok_out.last) || (len == '0)) state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      len   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        len <= len_clamped;
        idx <= '0;
      end else if (issue && !issue_last) begin
        // The final row is not incremented past, so the address holds at len-1.
        idx <= idx + 1'b1;
      end
    end
  end

  valid_delay_line #(.DEPTH(PIPE_DEPTH)) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .token_in  (tok_in),
    .token_out (tok_out)
  );

  assign mac_en    = tok_out.valid;
  assign mac_first = tok_out.valid & tok_out.first;
  assign mac_last  = tok_out.valid & tok_out.last;
  assign busy      = (state == ISSUE) || (state == DRAIN && len != '0);
  assign done      = (state == DONE);
  assign act_addr  = idx;

  for (genvar g = 0; g < NUM_NODES; g++) begin : g_node
    assign rom_addr[g*ADDR_WIDTH +: ADDR_WIDTH] = idx;
  end

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// tb/tb_weight_fetch_sequencer.sv - directed self-checking bench for weight_fetch_sequencer
module tb_weight_fetch_sequencer;

  localparam int AW = 16;
  localparam int NN = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, hold;
  logic [AW-1:0] depth_cfg;

  logic busy1, done1, en1, f1, l1;
  logic [AW*NN-1:0] rom1;
  logic [AW-1:0]    act1;
  logic busy3, done3, en3, f3, l3;
  logic [AW*NN-1:0] rom3;
  logic [AW-1:0]    act3;

  weight_fetch_sequencer #(.NUM_NODES(NN), .DEPTH(784), .ADDR_WIDTH(AW), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .depth_cfg(depth_cfg), .hold(hold),
    .busy(busy1), .done(done1), .rom_addr(rom1), .act_addr(act1),
    .mac_en(en1), .mac_first(f1), .mac_last(l1)
  );

  weight_fetch_sequencer #(.NUM_NODES(NN), .DEPTH(784), .ADDR_WIDTH(AW), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .depth_cfg(depth_cfg), .hold(hold),
    .busy(busy3), .done(done3), .rom_addr(rom3), .act_addr(act3),
    .mac_en(en3), .mac_first(f3), .mac_last(l3)
  );

  int total = 0;
  int bad   = 0;

  int beats, firsts, lasts, first_at, last_at, done_at, busy_cnt, max_addr, slice_bad, cnt;
  int addr_hist [0:1299];
  logic en_hist [0:1299];

  logic o_busy, o_done, o_en, o_f, o_l;
  logic [AW*NN-1:0] o_rom;
  logic [AW-1:0]    o_act;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int sel);
    if (sel == 0) begin
      o_busy = busy1; o_done = done1; o_en = en1; o_f = f1; o_l = l1; o_rom = rom1; o_act = act1;
    end else begin
      o_busy = busy3; o_done = done3; o_en = en3; o_f = f3; o_l = l3; o_rom = rom3; o_act = act3;
    end
  endtask

  // Start a layer, then watch the selected instance one cycle at a time.
  // Cycle c=1 is the first cycle after the start edge.
  task automatic run(input int d, input int hs, input int he, input int sel, input bit inj);
    beats = 0; firsts = 0; lasts = 0; first_at = -1; last_at = -1; done_at = -1;
    busy_cnt = 0; max_addr = 0; slice_bad = 0;
    depth_cfg = d[AW-1:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    depth_cfg = 16'd3;
    for (int c = 1; c < 1300; c++) begin
      hold  = (c >= hs && c <= he);
      start = inj && (c == 3);
      sample(sel);
      addr_hist[c] = int'(o_act);
      en_hist[c]   = o_en;
      if (o_busy) busy_cnt++;
      if (o_en) begin
        beats++;
        if (o_f) begin firsts++; first_at = c; end
        if (o_l) begin lasts++; last_at = c; end
      end
      if (int'(o_act) > max_addr) max_addr = int'(o_act);
      for (int g = 0; g < NN; g++)
        if (o_rom[g*AW +: AW] !== o_act) slice_bad++;
      if (o_done) begin done_at = c; break; end
      tick();
    end
    hold  = 1'b0;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; hold = 1'b0; depth_cfg = '0;
    tick(); tick();
    chk("rst_busy", int'(busy1), 0);
    chk("rst_done", int'(done1), 0);
    chk("rst_mac_en", int'(en1 | f1 | l1), 0);
    chk("rst_rom_zero", int'(rom1 != '0), 0);
    chk("rst_act", int'(act1), 0);
    rst_n = 1'b1;
    tick();

    // Basic full-depth run, RD_LAT=1
    run(784, 0, -1, 0, 1'b0);
    chk("basic_beats", beats, 784);
    chk("basic_first_at", first_at, 2);
    chk("basic_firsts", firsts, 1);
    chk("basic_last_at", last_at, 785);
    chk("basic_lasts", lasts, 1);
    chk("basic_done_at", done_at, 786);
    chk("basic_busy_cnt", busy_cnt, 785);
    chk("basic_max_addr", max_addr, 783);
    chk("basic_slice_bad", slice_bad, 0);
    idle(8);

    // Hold during cycles 3..5
    run(8, 3, 5, 0, 1'b0);
    chk("hold_addr_c3", addr_hist[3], 2);
    chk("hold_addr_c4", addr_hist[4], 2);
    chk("hold_addr_c5", addr_hist[5], 2);
    chk("hold_addr_c6", addr_hist[6], 2);
    chk("hold_addr_c7", addr_hist[7], 3);
    chk("hold_en_c3", int'(en_hist[3]), 1);
    chk("hold_gap_c4", int'(en_hist[4]), 0);
    chk("hold_gap_c5", int'(en_hist[5]), 0);
    chk("hold_gap_c6", int'(en_hist[6]), 0);
    chk("hold_en_c7", int'(en_hist[7]), 1);
    chk("hold_beats", beats, 8);
    chk("hold_last_at", last_at, 12);
    chk("hold_done_at", done_at, 13);
    idle(8);

    // Single-row layer
    run(1, 0, -1, 0, 1'b0);
    chk("len1_beats", beats, 1);
    chk("len1_first_at", first_at, 2);
    chk("len1_last_at", last_at, 2);
    chk("len1_done_at", done_at, 3);
    idle(8);

    // Empty layer
    run(0, 0, -1, 0, 1'b0);
    chk("len0_beats", beats, 0);
    chk("len0_busy_cnt", busy_cnt, 0);
    chk("len0_done_at", done_at, 2);
    idle(8);

    // Oversized layer is clamped
    run(1000, 0, -1, 0, 1'b0);
    chk("clamp_beats", beats, 784);
    chk("clamp_max_addr", max_addr, 783);
    chk("clamp_last_at", last_at, 785);
    chk("clamp_done_at", done_at, 786);
    idle(8);

    // RD_LAT=3 with a start pulse injected while busy
    run(5, 0, -1, 1, 1'b1);
    chk("lat3_first_at", first_at, 4);
    chk("lat3_last_at", last_at, 8);
    chk("lat3_beats", beats, 5);
    chk("lat3_busy_cnt", busy_cnt, 8);
    chk("lat3_done_at", done_at, 9);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy3 || en3 || done3) cnt++;
    end
    chk("lat3_no_restart", cnt, 0);
    idle(4);

    // Reset after 10 beats of a full run
    depth_cfg = 16'd784;
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 50 && cnt < 10; c++) begin
      if (en1) cnt++;
      if (cnt < 10) tick();
    end
    chk("mid_beats_seen", cnt, 10);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_busy", int'(busy1 | busy3), 0);
    chk("mid_rst_done", int'(done1 | done3), 0);
    chk("mid_rst_mac", int'(en1 | f1 | l1 | en3 | f3 | l3), 0);
    chk("mid_rst_addr", int'(rom1 != '0 || act1 != '0), 0);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done1 || busy1 || en1) cnt++;
    end
    chk("mid_quiet", cnt, 0);

    run(3, 0, -1, 0, 1'b0);
    chk("fresh_addr_c1", addr_hist[1], 0);
    chk("fresh_first_at", first_at, 2);
    chk("fresh_beats", beats, 3);
    chk("fresh_done_at", done_at, 5);
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
